instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_npc_sel.sv | 39 +++
 rtl/instr_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default reset PC and fetch timeout, and instruction field positions.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] IF_RESET_PC  = 32'h0000_3000;
    localparam int unsigned IF_MAX_WAIT  = 15;

    // Instruction word field positions
    localparam int unsigned OPCODE_MSB   = 31;
    localparam int unsigned OPCODE_LSB   = 26;
    localparam int unsigned FUNCT_MSB    = 5;
    localparam int unsigned FUNCT_LSB    = 0;
    localparam int unsigned TARGET_MSB   = 25;
    localparam int unsigned OPCODE_W     = 6;
    localparam int unsigned FUNCT_W      = 6;
    localparam int unsigned TARGET_W     = 26;

endpackage

// File: rtl/instr_fetch_npc_sel.sv
// Next-PC selection (combinational).
//   pc        : address of the executing instruction
//   target    : IR[25:0] jump target field
//   imm_ext   : sign-extended branch offset in words
//   branch    : bit0 = beq, bit1 = bne
//   zero      : ALU zero flag
//   jump      : unconditional jump, highest priority
//   next_pc_c : selected next PC
module npc_sel
    import instr_fetch_pkg::*;
(
    input  logic [XLEN-1:0]     pc,
    input  logic [TARGET_W-1:0] target,
    input  logic [XLEN-1:0]     imm_ext,
    input  logic [1:0]          branch,
    input  logic                zero,
    input  logic                jump,
    output logic [XLEN-1:0]     next_pc_c
);

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] branch_tgt;
    logic            taken;

    assign pc_plus4   = pc + 32'd4;
    assign branch_tgt = pc_plus4 + (imm_ext << 2);
    assign taken      = (branch[0] & zero) | (branch[1] & ~zero);

    // Jump beats branch beats sequential
    always_comb begin
        next_pc_c = pc_plus4;
        if (jump) begin
            next_pc_c = {pc_plus4[31:28], target, 2'b00};
        end else if (taken) begin
            next_pc_c = branch_tgt;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word per instruction from imem,
// holds it in IR during execution, then advances PC via npc_sel.
//   clk, rst_n             : clock, async active-low reset
//   imem_req/addr          : read request and word-aligned address
//   imem_ack/rdata         : read data valid and instruction word
//   branch, zero, jump,
//   imm_ext                : next-PC controls, used in the non-stalled EXEC cycle
//   stall                  : hold current instruction in EXEC
//   instr, opcode, funct   : IR and its decoder fields
//   pc                     : address of the IR instruction
//   instr_valid            : IR is executing
//   retired                : completed instruction count
//   fetch_err              : sticky imem timeout
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter int unsigned MAX_WAIT = IF_MAX_WAIT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     imem_rdata,
    input  logic [1:0]          branch,
    input  logic                zero,
    input  logic                jump,
    input  logic [XLEN-1:0]     imm_ext,
    input  logic                stall,
    output logic [XLEN-1:0]     instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNCT_W-1:0]  funct,
    output logic [XLEN-1:0]     pc,
    output logic                instr_valid,
    output logic [XLEN-1:0]     retired,
    output logic                fetch_err
);

    localparam int unsigned     WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [31:0]     PC_INIT   = {RESET_PC[31:2], 2'b00};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   retired_q, retired_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   next_pc_c;

    npc_sel u_npc_sel (
        .pc        (pc_q),
        .target    (ir_q[TARGET_MSB:0]),
        .imm_ext   (imm_ext),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .next_pc_c (next_pc_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_INIT;
            ir_q      <= '0;
            addr_q    <= PC_INIT;
            retired_q <= '0;
            wait_q    <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            addr_q    <= addr_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        addr_d    = addr_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d      = next_pc_c;
                    addr_d    = next_pc_c;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // req/valid are registered copies of the upcoming state
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_EXEC);
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = ir_q;
    assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign funct       = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;
    assign fetch_err   = err_q;

endmodule
